// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// requester and the load/store requester. At most one access is granted per
// cycle. Data wins contention unless fetch has lost STARVE_LIMIT consecutive
// contended grants. Read data (one-cycle latency) is steered back to the
// requester that owned the read. Out-of-range requests are acknowledged but
// never reach the memory.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   stall                   blocks new grants (outstanding reads still return)
//   inst_req/inst_addr      fetch request; inst_ack/inst_rvalid/inst_rdata
//   data_rd_req/data_wr_req load/store request with data_addr/wdata/wbyte;
//                           data_ack/data_rvalid/data_rdata
//   err_range, err_illegal  one-cycle error pulses in the ack cycle
//   mem_*                   memory strobes/addresses (word addressed),
//                           mem_read_data returns one cycle after the strobe
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 18,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wbyte,
  output logic        data_ack,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        err_range,
  output logic        err_illegal,
  output logic        mem_read_ready,
  output logic [29:0] mem_read_address,
  output logic        mem_write_ready,
  output logic [29:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_byte,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  // Any address bit at or above ADDR_WIDTH marks the access as unbacked.
  function automatic logic f_out_of_range(input logic [31:0] addr);
    f_out_of_range = |(addr >> ADDR_WIDTH);
  endfunction

  logic [3:0] r_starve_cnt;
  owner_e     r_rd_owner;
  logic       r_rd_oor;

  logic w_gnt_inst;
  logic w_gnt_data;
  logic w_is_store;
  logic w_is_load;
  logic w_inst_oor;
  logic w_data_oor;
  logic w_inst_rvalid;
  logic w_data_rvalid;
  logic w_unused;

  assign w_inst_oor = f_out_of_range(inst_addr);
  assign w_data_oor = f_out_of_range(data_addr);
  // Simultaneous rd+wr is treated as a store.
  assign w_is_store = w_gnt_data & data_wr_req;
  assign w_is_load  = w_gnt_data & ~data_wr_req;
  // Byte offsets are irrelevant to word-addressed memory.
  assign w_unused   = ^{inst_addr[1:0], data_addr[1:0]};

  // Grant decision: data priority unless fetch has starved to the limit.
  always_comb begin
    w_gnt_inst = 1'b0;
    w_gnt_data = 1'b0;
    if (reset || stall) begin
      w_gnt_inst = 1'b0;
      w_gnt_data = 1'b0;
    end else if ((data_rd_req || data_wr_req) &&
                 (!inst_req || (r_starve_cnt != LP_LIMIT))) begin
      w_gnt_data = 1'b1;
    end else if (inst_req) begin
      w_gnt_inst = 1'b1;
    end else begin
      w_gnt_inst = 1'b0;
      w_gnt_data = 1'b0;
    end
  end

  // Memory strobes; address/data lines stay at zero unless strobed.
  always_comb begin
    mem_read_ready    = 1'b0;
    mem_read_address  = 30'd0;
    mem_write_ready   = 1'b0;
    mem_write_address = 30'd0;
    mem_write_data    = 32'd0;
    mem_write_byte    = 4'd0;
    if (w_is_store && !w_data_oor) begin
      mem_write_ready   = 1'b1;
      mem_write_address = data_addr[31:2];
      mem_write_data    = data_wdata;
      mem_write_byte    = data_wbyte;
    end else if (w_is_load && !w_data_oor) begin
      mem_read_ready   = 1'b1;
      mem_read_address = data_addr[31:2];
    end else if (w_gnt_inst && !w_inst_oor) begin
      mem_read_ready   = 1'b1;
      mem_read_address = inst_addr[31:2];
    end else begin
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
    end
  end

  assign inst_ack    = w_gnt_inst;
  assign data_ack    = w_gnt_data;
  assign err_range   = (w_gnt_data & w_data_oor) | (w_gnt_inst & w_inst_oor);
  assign err_illegal = w_gnt_data & data_rd_req & data_wr_req;

  // Starvation counter and read-owner tag for the next-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
      r_rd_owner   <= OWN_NONE;
      r_rd_oor     <= 1'b0;
    end else begin
      if (!inst_req || w_gnt_inst) begin
        r_starve_cnt <= 4'd0;
      end else if (w_gnt_data && (r_starve_cnt != LP_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end

      if (w_gnt_inst) begin
        r_rd_owner <= OWN_INST;
        r_rd_oor   <= w_inst_oor;
      end else if (w_is_load) begin
        r_rd_owner <= OWN_DATA;
        r_rd_oor   <= w_data_oor;
      end else begin
        r_rd_owner <= OWN_NONE;
        r_rd_oor   <= 1'b0;
      end
    end
  end

  // Reset in the response cycle drops the pending reply; out-of-range
  // reads still pulse rvalid but return zero.
  assign w_inst_rvalid = (r_rd_owner == OWN_INST) & ~reset;
  assign w_data_rvalid = (r_rd_owner == OWN_DATA) & ~reset;
  assign inst_rvalid   = w_inst_rvalid;
  assign data_rvalid   = w_data_rvalid;
  assign inst_rdata    = (w_inst_rvalid && !r_rd_oor) ? mem_read_data : 32'd0;
  assign data_rdata    = (w_data_rvalid && !r_rd_oor) ? mem_read_data : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW  = 18;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset, stall, inst_req, data_rd_req, data_wr_req;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wbyte;
  logic        inst_ack, inst_rvalid, data_ack, data_rvalid, err_range, err_illegal;
  logic [31:0] inst_rdata, data_rdata, mem_write_data, mem_read_data;
  logic        mem_read_ready, mem_write_ready;
  logic [29:0] mem_read_address, mem_write_address;
  logic [3:0]  mem_write_byte;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_rd_req(data_rd_req), .data_wr_req(data_wr_req), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wbyte(data_wbyte), .data_ack(data_ack),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .err_range(err_range), .err_illegal(err_illegal),
    .mem_read_ready(mem_read_ready), .mem_read_address(mem_read_address),
    .mem_write_ready(mem_write_ready), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_byte(mem_write_byte),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Preloaded memory image shared by the environment memory and the model.
  function automatic logic [31:0] init_word(input int w);
    if (w == 32'h40) return 32'h1122_3344;
    return (32'(w) * 32'h0100_0193) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Environment: single-port synchronous memory driven by the DUT strobes.
  logic [31:0] env_mem [0:65535];
  bit          env_wr  [0:65535];
  logic [31:0] env_rdata;
  assign mem_read_data = env_rdata;

  function automatic logic [31:0] env_word(input int a);
    return env_wr[a] ? env_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_write_ready) begin
      env_mem[int'(mem_write_address[15:0])] <=
        merge(env_word(int'(mem_write_address[15:0])), mem_write_data, mem_write_byte);
      env_wr[int'(mem_write_address[15:0])] <= 1'b1;
    end
    if (mem_read_ready) env_rdata <= env_word(int'(mem_read_address[15:0]));
  end

  // Reference model state.
  logic [31:0] ref_mem [0:65535];
  bit          ref_wr  [0:65535];
  int          s_cnt;
  int          p_owner;      // 0 none, 1 fetch, 2 load
  bit          p_oor;
  logic [31:0] p_data;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int w;
    w = int'(a[17:2]);
    return ref_wr[w] ? ref_mem[w] : init_word(w);
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
    return {32'd0, a} >= (64'd1 << AW);
  endfunction

  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic        got_iack, got_dack, s_iv, s_dv, s_erng, s_eill, s_mrr, s_mwr;
  logic [31:0] s_ird, s_drd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance it.
  task automatic cycle();
    bit gi, gd, ia, da, st, ld, od, oi, ev_i, ev_d;
    @(negedge clk);
    ia = inst_req; da = data_rd_req || data_wr_req;
    gi = 1'b0; gd = 1'b0;
    if (!(reset || stall)) begin
      if (ia && da) begin
        if (s_cnt == LIM) gi = 1'b1; else gd = 1'b1;
      end else if (ia) gi = 1'b1;
      else if (da) gd = 1'b1;
    end
    st = gd && data_wr_req; ld = gd && !data_wr_req;
    od = is_oor(data_addr); oi = is_oor(inst_addr);
    chk("inst_ack", {31'd0, inst_ack}, {31'd0, gi});
    chk("data_ack", {31'd0, data_ack}, {31'd0, gd});
    chk("mem_write_ready", {31'd0, mem_write_ready}, {31'd0, st && !od});
    chk("mem_read_ready", {31'd0, mem_read_ready}, {31'd0, (ld && !od) || (gi && !oi)});
    if (st && !od) begin
      chk("wr_addr", {2'b00, mem_write_address}, data_addr >> 2);
      chk("wr_data", mem_write_data, data_wdata);
      chk("wr_byte", {28'd0, mem_write_byte}, {28'd0, data_wbyte});
    end
    if (ld && !od) chk("rd_addr_data", {2'b00, mem_read_address}, data_addr >> 2);
    if (gi && !oi) chk("rd_addr_inst", {2'b00, mem_read_address}, inst_addr >> 2);
    if (!gi && !gd) begin
      chk("idle_raddr", {2'b00, mem_read_address}, 32'd0);
      chk("idle_waddr", {2'b00, mem_write_address}, 32'd0);
      chk("idle_wdata", mem_write_data, 32'd0);
      chk("idle_wbyte", {28'd0, mem_write_byte}, 32'd0);
    end
    chk("err_range", {31'd0, err_range}, {31'd0, (gd && od) || (gi && oi)});
    chk("err_illegal", {31'd0, err_illegal}, {31'd0, gd && data_rd_req && data_wr_req});
    ev_i = (p_owner == 1) && !reset;
    ev_d = (p_owner == 2) && !reset;
    chk("inst_rvalid", {31'd0, inst_rvalid}, {31'd0, ev_i});
    chk("data_rvalid", {31'd0, data_rvalid}, {31'd0, ev_d});
    chk("inst_rdata", inst_rdata, (ev_i && !p_oor) ? p_data : 32'd0);
    chk("data_rdata", data_rdata, (ev_d && !p_oor) ? p_data : 32'd0);
    got_iack = inst_ack; got_dack = data_ack;
    s_iv = inst_rvalid; s_dv = data_rvalid; s_ird = inst_rdata; s_drd = data_rdata;
    s_erng = err_range; s_eill = err_illegal; s_mrr = mem_read_ready; s_mwr = mem_write_ready;
    @(posedge clk);
    if (reset) begin
      s_cnt = 0; p_owner = 0; p_oor = 1'b0; p_data = 32'd0;
    end else begin
      if (!ia || gi) s_cnt = 0;
      else if (gd && s_cnt < LIM) s_cnt++;
      p_owner = 0; p_oor = 1'b0; p_data = 32'd0;
      if (gi) begin
        p_owner = 1; p_oor = oi; p_data = oi ? 32'd0 : ref_read(inst_addr);
      end else if (ld) begin
        p_owner = 2; p_oor = od; p_data = od ? 32'd0 : ref_read(data_addr);
      end
      if (st && !od) begin
        ref_mem[int'(data_addr[17:2])] = merge(ref_read(data_addr), data_wdata, data_wbyte);
        ref_wr[int'(data_addr[17:2])]  = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom | 32'h0004_0000;
    return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [9:0] pat;
    int r;
    s_cnt = 0; p_owner = 0; p_oor = 1'b0; p_data = 32'd0;
    reset = 1'b1; stall = 1'b0; inst_req = 1'b1; inst_addr = 32'd0;
    data_rd_req = 1'b0; data_wr_req = 1'b0; data_addr = 32'd0;
    data_wdata = 32'd0; data_wbyte = 4'd0;

    // Reset with a pending fetch, then first fetch after release.
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    chk("boot_ack", {31'd0, got_iack}, 32'd1);
    inst_req = 1'b0;
    cycle();
    chk("boot_rvalid", {31'd0, s_iv}, 32'd1);
    chk("boot_word", s_ird, 32'h5A5A_5A5A);

    // Contended loads vs fetch: fetch wins every fifth grant.
    inst_req = 1'b1; data_rd_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      inst_addr = 32'(k) << 2;
      data_addr = 32'(k + 16) << 2;
      cycle();
      pat[k] = got_iack;
    end
    chk("starve_pattern", {22'd0, pat}, 32'h0000_0210);
    inst_req = 1'b0; data_rd_req = 1'b0;
    cycle();

    // Store with partial byte enables then load the same word.
    data_wr_req = 1'b1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF; data_wbyte = 4'b0011;
    cycle();
    data_wr_req = 1'b0; data_rd_req = 1'b1;
    cycle();
    data_rd_req = 1'b0;
    cycle();
    chk("store_load_word", s_drd, 32'h1122_BEEF);

    // Out-of-range load.
    data_rd_req = 1'b1; data_addr = 32'h0004_0000;
    cycle();
    chk("oor_err", {31'd0, s_erng}, 32'd1);
    chk("oor_no_strobe", {31'd0, s_mrr}, 32'd0);
    data_rd_req = 1'b0;
    cycle();
    chk("oor_rvalid", {31'd0, s_dv}, 32'd1);
    chk("oor_rdata", s_drd, 32'd0);

    // Both data requests high: store only, illegal pulse.
    data_rd_req = 1'b1; data_wr_req = 1'b1; data_addr = 32'h200;
    data_wdata = 32'h1234_5678; data_wbyte = 4'hF;
    cycle();
    chk("illegal_err", {31'd0, s_eill}, 32'd1);
    chk("illegal_store", {31'd0, s_mwr}, 32'd1);
    data_rd_req = 1'b0; data_wr_req = 1'b0;
    cycle();
    chk("illegal_no_rvalid", {31'd0, s_dv}, 32'd0);

    // Stall after a fetch ack: reply still arrives, no new grants.
    inst_req = 1'b1; inst_addr = 32'h8;
    cycle();
    stall = 1'b1; inst_addr = 32'hC;
    cycle();
    chk("stall_rvalid", {31'd0, s_iv}, 32'd1);
    chk("stall_no_ack", {31'd0, got_iack}, 32'd0);
    cycle();
    chk("stall_no_ack2", {31'd0, got_iack}, 32'd0);
    stall = 1'b0;
    cycle();
    inst_req = 1'b0;
    cycle();

    // Reset after a load ack suppresses the reply.
    data_rd_req = 1'b1; data_addr = 32'h10;
    cycle();
    data_rd_req = 1'b0; reset = 1'b1;
    cycle();
    chk("reset_drop_rvalid", {31'd0, s_dv}, 32'd0);
    reset = 1'b0;
    cycle();

    // Randomized traffic; requests are held until acknowledged.
    got_iack = 1'b0; got_dack = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!inst_req || got_iack) begin
        inst_req  = ($urandom_range(0, 3) != 0);
        inst_addr = rand_addr();
      end
      if (!(data_rd_req || data_wr_req) || got_dack) begin
        r = $urandom_range(0, 9);
        data_rd_req = (r <= 3) || (r == 9);
        data_wr_req = (r >= 4 && r <= 7) || (r == 9);
        data_addr   = rand_addr();
        data_wdata  = $urandom;
        data_wbyte  = 4'($urandom_range(0, 15));
      end
      stall = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous `memory` instance between the pipeline's instruction-fetch requester and its load/store requester, so the three-stage core can run from a unified memory image instead of split imem/dmem. Each cycle it grants at most one access, drives the memory strobes, and routes the one-cycle-latency read data back to the owning requester. Data accesses win by default; a starvation counter guarantees fetch progress; out-of-range addresses are rejected without touching memory.

## Interface
- `ADDR_WIDTH`, 18: byte-address bits backed by memory; any set bit in `addr[31:ADDR_WIDTH]` makes the request out of range.
- `STARVE_LIMIT`, 4: consecutive contended data grants after which fetch is forced to win. Legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  when high, no grants are issued.
- `inst_req`  in  1  fetch read request, held until acked.
- `inst_addr`  in  32  fetch byte address.
- `inst_ack`  out  1  fetch request accepted this cycle.
- `inst_rvalid`  out  1  fetch read data valid.
- `inst_rdata`  out  32  fetch read data.
- `data_rd_req`, `data_wr_req`  in  1 each  load / store request, held until acked.
- `data_addr`  in  32  load/store byte address.
- `data_wdata`  in  32  store data.
- `data_wbyte`  in  4  store byte enables.
- `data_ack`  out  1  load/store accepted this cycle.
- `data_rvalid`  out  1  load data valid.
- `data_rdata`  out  32  load data.
- `err_range`  out  1  one-cycle pulse: accepted request was out of range.
- `err_illegal`  out  1  one-cycle pulse: `data_rd_req` and `data_wr_req` were both high when acked.
- `mem_read_ready`  out  1  memory read strobe.
- `mem_read_address`  out  30  word address, `addr[31:2]`.
- `mem_write_ready`  out  1  memory write strobe.
- `mem_write_address`  out  30  word address, `addr[31:2]`.
- `mem_write_data`  out  32  write data.
- `mem_write_byte`  out  4  write byte enables.
- `mem_read_data`  in  32  read data, valid one cycle after `mem_read_ready`.

## Operation
- **Grant decision** (combinational, per cycle). No grant if `reset` or `stall`.
  - Only one requester active: that requester wins.
  - Both active: data wins, unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- **`starve_cnt`** (4-bit register):
  - increments on a data grant while `inst_req` is high;
  - clears on a fetch grant or when `inst_req` is low;
  - saturates at `STARVE_LIMIT`.
- **Ack timing:** `inst_ack` or `data_ack` equals the grant, in the same cycle. The requester may change its request on the next edge.
- **Store grant:** `mem_write_ready=1`; address, data and byte enables are passed through. No read response.
- **Load or fetch grant:** `mem_read_ready=1`; the owner tag is registered (`rd_owner_q`: NONE/INST/DATA).
- **Read response:** the next cycle, the tagged `*_rvalid` pulses for one cycle and `*_rdata = mem_read_data`. The untagged requester's rdata is 0.
- **Both data requests high:** treated as a store; `err_illegal` pulses; the load is not performed.
- **Out-of-range request:**
  - acked normally, but neither mem strobe is asserted;
  - `err_range` pulses in the ack cycle;
  - for a read, `*_rvalid` still pulses the next cycle with rdata = 0.
- **Idle outputs:** when no grant, `mem_*` address/data/byte outputs are 0.

## Timing
- **Reset values:** all acks, rvalids, mem strobes and error pulses are 0; rdata is 0; `starve_cnt=0`; `rd_owner_q=NONE`.
- **Latency:**
  - request → ack: 0 cycles;
  - ack → rvalid: exactly 1 cycle;
  - store is committed at the edge ending the ack cycle.
- **Throughput:** one access per cycle. Back-to-back reads to the same or different owners each return on consecutive cycles, with no bubbles.
- **Store then load to the same word in consecutive cycles:** the load returns the new data. This follows the memory's write-then-read ordering and requires no forwarding in this block.
- **`reset` asserted while a read is outstanding:** the rvalid for that read is suppressed and the tag cleared.
- **`stall` asserted while a read is outstanding:** the response is still delivered; only new grants are blocked.
- **`starve_cnt` boundary:** the fetch forced at `STARVE_LIMIT` clears the counter in the same edge, so data regains priority the following cycle.

## Test plan
- **Reset and idle:** reset for 3 cycles with `inst_req=1` → no ack, no strobes, all outputs 0. Release reset → `inst_ack` in the first cycle; `inst_rvalid` the next cycle with `inst_rdata` equal to the preloaded word at 0x0.
- **Load priority and starvation:** `inst_req` and `data_rd_req` held high continuously with `STARVE_LIMIT=4` → grant pattern D,D,D,D,I,D,D,D,D,I. Each rvalid goes to the correct owner with the correct word.
- **Store then load to the same word:** store 0xDEADBEEF, `wbyte=4'b0011`, to 0x100 (preloaded 0x11223344); the next cycle load 0x100 → `data_rdata = 0x1122BEEF` one cycle after the load ack.
- **Out-of-range load:** load at 0x0004_0000 with `ADDR_WIDTH=18` → `data_ack=1` and `err_range=1` in the same cycle; no mem strobe; `data_rvalid=1` with rdata 0 the next cycle.
- **Both data requests high:** `data_rd_req=data_wr_req=1` → store performed, `err_illegal` pulse, no `data_rvalid`.
- **Stall and reset with reads outstanding:**
  - `stall` raised the cycle after a fetch ack → `inst_rvalid` is still delivered, then no grants while `stall=1`;
  - `reset` raised the cycle after a load ack → no `data_rvalid`.
